// File: rtl/wb_pkg.sv
// Shared types for the result writeback unit. With WB_SKIP_INACTIVE_EN defined,
// each buffered vector also carries its per-element write mask.
package wb_pkg;

    localparam int WB_DATA_WIDTH = 16;
    localparam int WB_NUM_UNITS  = 4;
    localparam int WB_ADDR_WIDTH = 8;
    localparam int VEC_W         = WB_NUM_UNITS * WB_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    typedef struct packed {
        logic [VEC_W-1:0]         data;
        logic [WB_ADDR_WIDTH-1:0] base;
`ifdef WB_SKIP_INACTIVE_EN
        logic [WB_NUM_UNITS-1:0]  mask;
`endif
    } wb_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Circular FIFO for captured result vectors; a push while full is accepted
// only when a pop happens in the same cycle. DEPTH must be a power of two.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/result_writeback_unit.sv
// Buffers finished result vectors and streams them element by element onto a
// valid/ready memory write port. Option WB_SKIP_INACTIVE_EN skips masked-off elements.
module result_writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int NUM_UNITS  = WB_NUM_UNITS,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            res_valid,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] res_data,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [NUM_UNITS-1:0]            active_units,
    output logic                            mem_wr_valid,
    output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    input  logic                            mem_wr_ready,
    output logic                            vec_done,
    output logic                            res_overflow,
    output logic                            busy,
    output logic [15:0]                     vec_count
);

    localparam int               IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    state_t           state;
    state_t           next_state;
    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    wb_entry_t        work;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             retire;

    always_comb begin
        push_entry      = '0;
        push_entry.data = res_data;
        push_entry.base = base_addr;
`ifdef WB_SKIP_INACTIVE_EN
        push_entry.mask = active_units;
`endif
    end

    result_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (res_valid),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef WB_SKIP_INACTIVE_EN
    logic             first_found;
    logic             next_found;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] next_active;

    // Lowest active element of the head vector, and next active element after idx.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_active = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (head_entry.mask[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (work.mask[i] && (i > int'(idx))) begin
                next_found  = 1'b1;
                next_active = IDX_W'(i);
            end
        end
    end
`else
    logic unused_active_units;
    assign unused_active_units = ^active_units;
`endif

    always_comb begin
        next_state = state;
        next_idx   = idx;
        pop        = 1'b0;
        retire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                pop = 1'b1;
`ifdef WB_SKIP_INACTIVE_EN
                if (first_found) begin
                    next_idx   = first_idx;
                    next_state = WRITE;
                end else begin
                    next_idx   = '0;
                    retire     = 1'b1;
                    next_state = IDLE;
                end
`else
                next_idx   = '0;
                next_state = WRITE;
`endif
            end
            WRITE: begin
                if (mem_wr_ready) begin
`ifdef WB_SKIP_INACTIVE_EN
                    if (next_found) begin
                        next_idx = next_active;
                    end else begin
                        next_idx   = '0;
                        retire     = 1'b1;
                        next_state = fifo_empty ? IDLE : LOAD;
                    end
`else
                    if (idx != LAST_IDX) begin
                        next_idx = idx + IDX_W'(1);
                    end else begin
                        next_idx   = '0;
                        retire     = 1'b1;
                        next_state = fifo_empty ? IDLE : LOAD;
                    end
`endif
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address is base+idx so skipped elements still consume their slot.
    assign mem_wr_valid = (state == WRITE);
    assign mem_wr_addr  = work.base + ADDR_WIDTH'(idx);
    assign mem_wr_data  = work.data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign busy         = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            work         <= '0;
            idx          <= '0;
            vec_done     <= 1'b0;
            res_overflow <= 1'b0;
            vec_count    <= '0;
        end else begin
            state        <= next_state;
            idx          <= next_idx;
            vec_done     <= retire;
            res_overflow <= res_valid && fifo_full && !pop;
            if (pop) begin
                work <= head_entry;
            end
            if (retire) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback_unit.sv
// Directed bench for result_writeback_unit: latency, back-pressure, overflow,
// address wrap and mid-vector reset; masked vectors only with WB_SKIP_INACTIVE_EN.
module tb_result_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic [63:0] res_data;
    logic [7:0]  base_addr;
    logic [3:0]  active_units;
    logic        mem_wr_valid;
    logic [7:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        vec_done;
    logic        res_overflow;
    logic        busy;
    logic [15:0] vec_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int ready_mode   = 1;
    int ready_ptr    = 0;
    int stall_cycles = 0;
    logic [7:0]  ready_pat;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_addr  = '0;
    logic [15:0] prev_data  = '0;

    logic [7:0]  log_addr [$];
    logic [15:0] log_data [$];
    int          log_cyc  [$];
    int          done_cyc [$];
    int          ovf_cyc  [$];

    result_writeback_unit dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .base_addr    (base_addr),
        .active_units (active_units),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .vec_done     (vec_done),
        .res_overflow (res_overflow),
        .busy         (busy),
        .vec_count    (vec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        case (ready_mode)
            0:       mem_wr_ready = 1'b0;
            1:       mem_wr_ready = 1'b1;
            default: begin
                mem_wr_ready = ready_pat[ready_ptr % 8];
                ready_ptr++;
            end
        endcase
    end

    // Mid-cycle monitor: logs transfers and pulses, and checks stalled writes hold.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (stall_prev) begin
                checkOutput("hold_valid", 32'(mem_wr_valid), 32'd1);
                checkOutput("hold_addr", 32'(mem_wr_addr), 32'(prev_addr));
                checkOutput("hold_data", 32'(mem_wr_data), 32'(prev_data));
            end
            if (mem_wr_valid && mem_wr_ready) begin
                log_addr.push_back(mem_wr_addr);
                log_data.push_back(mem_wr_data);
                log_cyc.push_back(cyc);
            end
            if (mem_wr_valid && !mem_wr_ready) stall_cycles++;
            if (vec_done) done_cyc.push_back(cyc);
            if (res_overflow) ovf_cyc.push_back(cyc);
            stall_prev = mem_wr_valid && !mem_wr_ready;
            prev_addr  = mem_wr_addr;
            prev_data  = mem_wr_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic logic [63:0] vec_of(input logic [15:0] tv);
        return {tv + 16'd3, tv + 16'd2, tv + 16'd1, tv};
    endfunction

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cyc.delete();
        ovf_cyc.delete();
        stall_cycles = 0;
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] base,
                                 input logic [3:0] mask, output int t);
        @(negedge clk);
        res_valid    = 1'b1;
        res_data     = data;
        base_addr    = base;
        active_units = mask;
        t            = cyc;
        @(negedge clk);
        res_valid    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #3;
    endtask

    task automatic expect_vector(input string tag, input int first, input logic [7:0] base,
                                 input logic [15:0] tv);
        for (int i = 0; i < 4; i++) begin
            if (first + i < log_addr.size()) begin
                checkOutput({tag, "_addr"}, 32'(log_addr[first+i]), 32'(8'(base + 8'(i))));
                checkOutput({tag, "_data"}, 32'(log_data[first+i]), 32'(16'(tv + 16'(i))));
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int t_d;
        int n;
        ready_pat    = 8'b0110_1001;
        reset        = 1'b0;
        res_valid    = 1'b0;
        res_data     = '0;
        base_addr    = '0;
        active_units = '0;
        mem_wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_valid", 32'(mem_wr_valid), 32'd0);
        checkOutput("rst_addr", 32'(mem_wr_addr), 32'd0);
        checkOutput("rst_data", 32'(mem_wr_data), 32'd0);
        checkOutput("rst_done", 32'(vec_done), 32'd0);
        checkOutput("rst_ovf", 32'(res_overflow), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_count", 32'(vec_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] single vector, ready always high");
        clear_logs();
        applyStimulus(64'h0004_0003_0002_0001, 8'h10, 4'hF, t);
        wait_idle("t1_idle");
        checkOutput("t1_writes", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checkOutput("t1_addr", 32'(log_addr[i]), 32'h10 + 32'(i));
            checkOutput("t1_data", 32'(log_data[i]), 32'(i + 1));
            checkOutput("t1_cycle", 32'(log_cyc[i]), 32'(t + 3 + i));
        end
        checkOutput("t1_done_n", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) checkOutput("t1_done_cyc", 32'(done_cyc[0]), 32'(t + 7));
        checkOutput("t1_count", 32'(vec_count), 32'd1);

        $display("[TB] back-pressure");
        clear_logs();
        ready_ptr  = 0;
        ready_mode = 2;
        applyStimulus(vec_of(16'h0A10), 8'h40, 4'hF, t);
        wait_idle("t2_idle");
        ready_mode = 1;
        checkOutput("t2_writes", 32'(log_addr.size()), 32'd4);
        expect_vector("t2", 0, 8'h40, 16'h0A10);
        checkOutput("t2_stalled", 32'(stall_cycles > 0), 32'd1);
        checkOutput("t2_done_n", 32'(done_cyc.size()), 32'd1);
        checkOutput("t2_count", 32'(vec_count), 32'd2);

        $display("[TB] overflow");
        clear_logs();
        ready_mode = 0;
        applyStimulus(vec_of(16'h0B00), 8'h50, 4'hF, t);
        n = 0;
        while (!mem_wr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t3_stall_valid", 32'(mem_wr_valid), 32'd1);
        applyStimulus(vec_of(16'h0C00), 8'h60, 4'hF, t);
        applyStimulus(vec_of(16'h0D00), 8'h70, 4'hF, t);
        applyStimulus(vec_of(16'h0E00), 8'h80, 4'hF, t_d);
        repeat (3) @(negedge clk);
        #3;
        checkOutput("t3_ovf_n", 32'(ovf_cyc.size()), 32'd1);
        if (ovf_cyc.size() > 0) checkOutput("t3_ovf_cyc", 32'(ovf_cyc[0]), 32'(t_d + 1));
        checkOutput("t3_held_addr", 32'(mem_wr_addr), 32'h50);
        checkOutput("t3_held_data", 32'(mem_wr_data), 32'h0B00);
        checkOutput("t3_no_writes", 32'(log_addr.size()), 32'd0);
        ready_mode = 1;
        wait_idle("t3_idle");
        checkOutput("t3_writes", 32'(log_addr.size()), 32'd12);
        expect_vector("t3a", 0, 8'h50, 16'h0B00);
        expect_vector("t3b", 4, 8'h60, 16'h0C00);
        expect_vector("t3c", 8, 8'h70, 16'h0D00);
        checkOutput("t3_done_n", 32'(done_cyc.size()), 32'd3);
        checkOutput("t3_count", 32'(vec_count), 32'd5);

        $display("[TB] address wrap");
        clear_logs();
        applyStimulus(vec_of(16'h0F00), 8'hFE, 4'hF, t);
        wait_idle("t4_idle");
        checkOutput("t4_writes", 32'(log_addr.size()), 32'd4);
        expect_vector("t4", 0, 8'hFE, 16'h0F00);
        if (log_addr.size() > 3) begin
            checkOutput("t4_wrap_addr2", 32'(log_addr[2]), 32'h00);
            checkOutput("t4_wrap_addr3", 32'(log_addr[3]), 32'h01);
        end
        checkOutput("t4_count", 32'(vec_count), 32'd6);

        $display("[TB] reset mid-vector");
        clear_logs();
        applyStimulus(vec_of(16'h0100), 8'h80, 4'hF, t);
        n = 0;
        while (cyc != t + 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(mem_wr_valid), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_count", 32'(vec_count), 32'd0);
        checkOutput("t5_partial_writes", 32'(log_addr.size()), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        applyStimulus(vec_of(16'h0200), 8'h90, 4'hF, t);
        wait_idle("t5_idle");
        checkOutput("t5_writes", 32'(log_addr.size()), 32'd4);
        expect_vector("t5", 0, 8'h90, 16'h0200);
        if (log_cyc.size() > 0) checkOutput("t5_first_cyc", 32'(log_cyc[0]), 32'(t + 3));
        checkOutput("t5_done_n", 32'(done_cyc.size()), 32'd1);
        checkOutput("t5_count", 32'(vec_count), 32'd1);

`ifdef WB_SKIP_INACTIVE_EN
        $display("[TB] skip inactive elements");
        clear_logs();
        applyStimulus(vec_of(16'h0500), 8'h20, 4'b0101, t);
        wait_idle("t6_idle");
        checkOutput("t6_writes", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() > 1) begin
            checkOutput("t6_addr0", 32'(log_addr[0]), 32'h20);
            checkOutput("t6_data0", 32'(log_data[0]), 32'h0500);
            checkOutput("t6_addr1", 32'(log_addr[1]), 32'h22);
            checkOutput("t6_data1", 32'(log_data[1]), 32'h0502);
            checkOutput("t6_cyc1", 32'(log_cyc[1]), 32'(t + 4));
        end
        checkOutput("t6_done_n", 32'(done_cyc.size()), 32'd1);
        checkOutput("t6_count", 32'(vec_count), 32'd2);

        clear_logs();
        applyStimulus(vec_of(16'h0600), 8'h30, 4'b0000, t);
        wait_idle("t7_idle");
        checkOutput("t7_writes", 32'(log_addr.size()), 32'd0);
        checkOutput("t7_done_n", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) checkOutput("t7_done_cyc", 32'(done_cyc[0]), 32'(t + 3));
        checkOutput("t7_count", 32'(vec_count), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
